// File: rtl/a2d_rr_scheduler_if.sv
// Signal bundle between the A2D round-robin scheduler, its SPI master and its consumers.
// The master modport is the scheduler's view; the slave modport is the environment's view.
interface a2d_rr_scheduler_if;
  logic        nxt;
  logic        wrt;
  logic [15:0] wrt_data;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        vld;
  logic        busy;
  logic        err;

  modport master (
    input  nxt, done, rd_data,
    output wrt, wrt_data, lft_ld, rght_ld, steer_pot, batt, vld, busy, err
  );

  modport slave (
    output nxt, done, rd_data,
    input  wrt, wrt_data, lft_ld, rght_ld, steer_pot, batt, vld, busy, err
  );
endinterface

// File: rtl/a2d_rr_scheduler.sv
// Round-robin SPI A2D sequencer: left, right, steer, battery; one command + one read per channel.
// Optional transaction watchdog and sticky err flag enabled by defining A2D_WDOG_EN.
module a2d_rr_scheduler #(
  parameter logic [2:0]  CH_LFT     = 3'd0,
  parameter logic [2:0]  CH_RGHT    = 3'd4,
  parameter logic [2:0]  CH_STEER   = 3'd5,
  parameter logic [2:0]  CH_BATT    = 3'd6,
  parameter int unsigned GAP_CYCLES = 2
`ifdef A2D_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 65536
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  a2d_rr_scheduler_if.master    a2d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    GAP  = 2'd2,
    RD   = 2'd3
  } state_t;

  localparam int unsigned    GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

  state_t        state_q, state_d;
  logic [1:0]    ch_idx_q, ch_idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wrt_q, wrt_d;
  logic [15:0]   wrt_data_q, wrt_data_d;
  logic [11:0]   lft_q, lft_d;
  logic [11:0]   rght_q, rght_d;
  logic [11:0]   steer_q, steer_d;
  logic [11:0]   batt_q, batt_d;
  logic          vld_q, vld_d;
  logic          done_ok;
  logic          rd_hi_unused;

`ifdef A2D_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0]   wdog_q, wdog_d;
  logic          err_q, err_d;
`endif

  function automatic logic [15:0] cmd_word(input logic [1:0] idx);
    logic [2:0] ch;
    case (idx)
      2'd0:    ch = CH_LFT;
      2'd1:    ch = CH_RGHT;
      2'd2:    ch = CH_STEER;
      default: ch = CH_BATT;
    endcase
    return {2'b00, ch, 11'h000};
  endfunction

  // A done that lands in the wrt cycle cannot belong to this transaction.
  assign done_ok      = a2d.done && !wrt_q;
  assign rd_hi_unused = ^a2d.rd_data[15:12];

  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    gap_d      = gap_q;
    wrt_d      = 1'b0;
    wrt_data_d = wrt_data_q;
    lft_d      = lft_q;
    rght_d     = rght_q;
    steer_d    = steer_q;
    batt_d     = batt_q;
    vld_d      = 1'b0;
`ifdef A2D_WDOG_EN
    err_d      = err_q;
    wdog_d     = wdog_q;
`endif

    case (state_q)
      IDLE: begin
        if (a2d.nxt) begin
          state_d    = CMD;
          ch_idx_d   = 2'd0;
          wrt_d      = 1'b1;
          wrt_data_d = cmd_word(2'd0);
`ifdef A2D_WDOG_EN
          err_d      = 1'b0;
`endif
        end
      end
      CMD: begin
        if (done_ok) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d    = RD;
          wrt_d      = 1'b1;
          wrt_data_d = cmd_word(ch_idx_q);
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      RD: begin
        if (done_ok) begin
          case (ch_idx_q)
            2'd0:    lft_d   = a2d.rd_data[11:0];
            2'd1:    rght_d  = a2d.rd_data[11:0];
            2'd2:    steer_d = a2d.rd_data[11:0];
            default: batt_d  = a2d.rd_data[11:0];
          endcase
          if (ch_idx_q == 2'd3) begin
            state_d = IDLE;
            vld_d   = 1'b1;
          end else begin
            state_d    = CMD;
            ch_idx_d   = ch_idx_q + 2'd1;
            wrt_d      = 1'b1;
            wrt_data_d = cmd_word(ch_idx_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef A2D_WDOG_EN
    // Timeout takes priority only when no done arrived; partial results are kept.
    if (wrt_d) begin
      wdog_d = '0;
    end else if (state_q == CMD || state_q == RD) begin
      if (!done_ok && wdog_q == WDOG_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wdog_d = wdog_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_idx_q   <= '0;
      gap_q      <= '0;
      wrt_q      <= 1'b0;
      wrt_data_q <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
      steer_q    <= '0;
      batt_q     <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_idx_q   <= ch_idx_d;
      gap_q      <= gap_d;
      wrt_q      <= wrt_d;
      wrt_data_q <= wrt_data_d;
      lft_q      <= lft_d;
      rght_q     <= rght_d;
      steer_q    <= steer_d;
      batt_q     <= batt_d;
      vld_q      <= vld_d;
    end
  end

`ifdef A2D_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign a2d.err = err_q;
`else
  assign a2d.err = 1'b0;
`endif

  assign a2d.wrt       = wrt_q;
  assign a2d.wrt_data  = wrt_data_q;
  assign a2d.lft_ld    = lft_q;
  assign a2d.rght_ld   = rght_q;
  assign a2d.steer_pot = steer_q;
  assign a2d.batt      = batt_q;
  assign a2d.vld       = vld_q;
  assign a2d.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_rr_scheduler.sv
// Self-checking bench for a2d_rr_scheduler: SPI responder model, vector table, scoreboard on vld.
// Define A2D_WDOG_EN for the build to also exercise the watchdog path (WDOG_CYCLES=64).
module tb_a2d_rr_scheduler;
  localparam int unsigned GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  a2d_rr_scheduler_if bus();

  a2d_rr_scheduler #(
    .GAP_CYCLES(GAP)
`ifdef A2D_WDOG_EN
    , .WDOG_CYCLES(64)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .a2d (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0]  rd[4];
    logic [11:0]  ex[4];
    int unsigned  lat;
    bit           noise;
    bit           early;
  } vec_t;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] s;
    logic [11:0] b;
  } res_t;

  vec_t vecs[5];
  res_t sb_q[$];
  logic [2:0] chs[4];

  // SPI responder model state
  logic [15:0] m_rd[4];
  int unsigned m_lat = 2;
  bit          m_noise = 1'b0;
  bit          m_early = 1'b0;
  int          m_drop = -1;
  int unsigned m_txn = 0;
  bit          m_busy = 1'b0;
  logic [15:0] wlog[$];
  int unsigned last_done_cyc = 0;
  int unsigned last_wrt_cyc = 0;
  int          vld_cnt = 0;

  task automatic serve();
    int unsigned idx;
    bit is_rd;
    idx   = m_txn % 8;
    is_rd = (idx % 2) == 1;
    m_busy = 1'b1;
    wlog.push_back(bus.wrt_data);
    last_wrt_cyc = cyc;
    if (is_rd) check("gap_len", cyc - last_done_cyc, GAP + 1);
    if (int'(m_txn) == m_drop) begin
      m_txn++;
      @(posedge clk); #1;
      m_busy = 1'b0;
      return;
    end
    m_txn++;
    if (m_early) begin
      bus.done = 1'b1;
      bus.rd_data = 16'hDEAD;
    end
    @(posedge clk); #1;
    bus.done = 1'b0;
    for (int i = 1; i < int'(m_lat); i++) begin
      check("wrt_in_txn", bus.wrt, 1'b0);
      @(posedge clk); #1;
    end
    bus.done = 1'b1;
    bus.rd_data = is_rd ? m_rd[idx/2] : 16'hBEEF;
    if (!is_rd) last_done_cyc = cyc;
    @(posedge clk); #1;
    bus.done = 1'b0;
    bus.rd_data = 16'h5A5A;
    if (m_noise && !is_rd) begin
      bus.done = 1'b1;
      bus.rd_data = 16'hFFFF;
      @(posedge clk); #1;
      bus.done = 1'b0;
    end
    m_busy = 1'b0;
  endtask

  initial begin
    bus.done = 1'b0;
    bus.rd_data = 16'h0000;
    @(posedge clk); #1;
    forever begin
      if (bus.wrt === 1'b1) serve();
      else begin
        @(posedge clk); #1;
      end
    end
  end

  always @(negedge clk) begin : mon
    res_t e;
    if (!rst && bus.vld === 1'b1) begin
      vld_cnt++;
      check("sb_nonempty_at_vld", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("lft_ld", bus.lft_ld, e.l);
        check("rght_ld", bus.rght_ld, e.r);
        check("steer_pot", bus.steer_pot, e.s);
        check("batt", bus.batt, e.b);
        check("busy_at_vld", bus.busy, 1'b0);
      end
    end
  end

  task automatic add_vec(input int i, input logic [15:0] r0, r1, r2, r3,
                         input logic [11:0] e0, e1, e2, e3,
                         input int unsigned lat, input bit noise, input bit early);
    vecs[i].rd[0] = r0; vecs[i].rd[1] = r1; vecs[i].rd[2] = r2; vecs[i].rd[3] = r3;
    vecs[i].ex[0] = e0; vecs[i].ex[1] = e1; vecs[i].ex[2] = e2; vecs[i].ex[3] = e3;
    vecs[i].lat = lat; vecs[i].noise = noise; vecs[i].early = early;
  endtask

  task automatic load_model(input int i);
    for (int k = 0; k < 4; k++) m_rd[k] = vecs[i].rd[k];
    m_lat   = vecs[i].lat;
    m_noise = vecs[i].noise;
    m_early = vecs[i].early;
    m_txn   = 0;
    wlog.delete();
  endtask

  task automatic push_exp(input int i);
    res_t e;
    e.l = vecs[i].ex[0];
    e.r = vecs[i].ex[1];
    e.s = vecs[i].ex[2];
    e.b = vecs[i].ex[3];
    sb_q.push_back(e);
  endtask

  task automatic pulse_nxt();
    bus.nxt = 1'b1;
    @(negedge clk);
    bus.nxt = 1'b0;
  endtask

  task automatic wait_vld(input int budget);
    int n;
    n = 0;
    while (bus.vld !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("vld_seen", bus.vld, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wrt"}, bus.wrt, 1'b0);
    check({tag, "_wrt_data"}, bus.wrt_data, 16'h0000);
    check({tag, "_lft"}, bus.lft_ld, 12'h000);
    check({tag, "_rght"}, bus.rght_ld, 12'h000);
    check({tag, "_steer"}, bus.steer_pot, 12'h000);
    check({tag, "_batt"}, bus.batt, 12'h000);
    check({tag, "_vld"}, bus.vld, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
  endtask

  task automatic run_vec(input int i);
    int vc0;
    logic [15:0] w;
    load_model(i);
    vc0 = vld_cnt;
    push_exp(i);
    pulse_nxt();
    wait_vld(2000);
    repeat (4) @(negedge clk);
    check("vld_once", vld_cnt, vc0 + 1);
    check("wrt_count", wlog.size(), 8);
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      w = {2'b00, chs[k/2], 11'h000};
      check("wrt_data_ch", wlog[k], w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int vc0;
    int n;
    int unsigned tcyc;
    chs[0] = 3'd0; chs[1] = 3'd4; chs[2] = 3'd5; chs[3] = 3'd6;
    add_vec(0, 16'h0123, 16'h0456, 16'h0789, 16'h0ABC, 12'h123, 12'h456, 12'h789, 12'hABC, 3, 0, 0);
    add_vec(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1, 0, 0);
    add_vec(2, 16'hF000, 16'hE001, 16'h1800, 16'h7FFE, 12'h000, 12'h001, 12'h800, 12'hFFE, 5, 1, 0);
    add_vec(3, 16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hC3C3, 12'h5A5, 12'hA5A, 12'hF0F, 12'h3C3, 2, 0, 1);
    add_vec(4, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 12'h001, 12'h002, 12'h004, 12'h008, 4, 1, 1);

    bus.nxt = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_wrt", bus.wrt, 1'b0);
    end

    for (int i = 0; i < 5; i++) run_vec(i);

    // nxt held high: no extra wrt mid-round, back-to-back round right after vld
    load_model(0);
    vc0 = vld_cnt;
    push_exp(0);
    push_exp(0);
    bus.nxt = 1'b1;
    @(negedge clk);
    wait_vld(2000);
    check("hold_no_extra_wrt", wlog.size(), 8);
    @(negedge clk);
    check("hold_restart_wrt", bus.wrt, 1'b1);
    check("hold_restart_busy", bus.busy, 1'b1);
    bus.nxt = 1'b0;
    wait_vld(2000);
    repeat (4) @(negedge clk);
    check("hold_wrt_total", wlog.size(), 16);
    check("hold_vld_total", vld_cnt, vc0 + 2);

    // reset in the middle of a round
    load_model(3);
    vc0 = vld_cnt;
    pulse_nxt();
    n = 0;
    while (bus.lft_ld !== 12'h5A5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("lft_before_rst", bus.lft_ld, 12'h5A5);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    n = 0;
    while (m_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      check("post_rst_busy", bus.busy, 1'b0);
      check("post_rst_wrt", bus.wrt, 1'b0);
    end
    check("post_rst_no_vld", vld_cnt, vc0);
    check("post_rst_wrt_count", wlog.size(), 3);
    run_vec(0);

`ifdef A2D_WDOG_EN
    // watchdog: third transaction never completes
    load_model(0);
    m_drop = 2;
    vc0 = vld_cnt;
    pulse_nxt();
    n = 0;
    while (bus.err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tcyc = cyc;
    check("wdog_err", bus.err, 1'b1);
    check("wdog_cycles", tcyc - last_wrt_cyc, 64);
    check("wdog_busy", bus.busy, 1'b0);
    check("wdog_lft", bus.lft_ld, 12'h123);
    check("wdog_rght_kept", bus.rght_ld, 12'h456);
    repeat (3) @(negedge clk);
    check("wdog_no_vld", vld_cnt, vc0);
    check("wdog_err_sticky", bus.err, 1'b1);
    m_drop = -1;
    load_model(1);
    push_exp(1);
    pulse_nxt();
    check("wdog_err_cleared", bus.err, 1'b0);
    wait_vld(2000);
    repeat (4) @(negedge clk);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
